issue_scheduler: RTL and testbench
==================================

# issue_scheduler

Out-of-order issue scheduler between register renaming and execute. Holds up to IQ_DEPTH renamed instructions and tracks per-physical-register busy bits. Wakes entries on writeback broadcasts and issues the oldest ready entry each cycle over a valid/ready handshake. A flush from the hazard controller squashes every held entry.

## Interface
- IQ_DEPTH, 16: scheduler entries; power of two, 4..32
- NUM_PREGS, 64: physical registers
- PREG_W, 6: physical register index width, log2(NUM_PREGS)
- TAG_W, 5: active-list tag width carried with each entry
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- disp_valid  in  1  renamed instruction offered
- disp_ready  out  1  scheduler accepts; transfer when disp_valid && disp_ready
- disp_uses_rs / disp_uses_rt / disp_uses_rw  in  1 each  operand/destination used
- disp_rs_phys / disp_rt_phys / disp_rd_phys  in  PREG_W each  physical indices
- disp_tag  in  TAG_W  active-list tag
- wb_valid  in  1  writeback broadcast
- wb_preg  in  PREG_W  physical register produced
- iss_valid  out  1  an entry is issuing
- iss_ready  in  1  execute accepts; transfer when iss_valid && iss_ready
- iss_rs_phys / iss_rt_phys / iss_rd_phys  out  PREG_W each
- iss_uses_rw  out  1
- iss_tag  out  TAG_W
- flush  in  1  squash all entries (branch mispredict)
- occupancy  out  $clog2(IQ_DEPTH)+1  valid entry count

## Operation
- Entry state: valid, rs/rt/rd phys, uses_rw, tag, rs_rdy, rt_rdy. Age matrix age[i][j] = 1 when entry i is older than j.
- Busy table: NUM_PREGS bits. Preg 0 is never busy; writes to it are ignored.
- Dispatch:
  - disp_ready = !rst && !flush && (occupancy < IQ_DEPTH).
  - On transfer, write the lowest-index free slot j.
  - rs_rdy = !disp_uses_rs || !busy[rs] || (wb_valid && wb_preg == rs). rt_rdy likewise.
  - Source readiness uses the busy value before this cycle's set, so rs == rd reads the old value.
  - age[i][j] = valid[i] for all i; age[j][*] = 0.
  - If disp_uses_rw and rd != 0, set busy[rd].
- Wakeup:
  - wb_valid clears busy[wb_preg].
  - Every valid entry with rs == wb_preg sets rs_rdy; same rule for rt.
- Select:
  - Candidate = valid && rs_rdy && rt_rdy, using registered flags only.
  - Issue the candidate i for which no other candidate k has age[k][i].
  - iss_valid = any candidate && !flush. iss_* fields are driven combinationally from the selected entry.
  - On transfer, clear valid[i] and column/row i of age.
  - Unaccepted issue: outputs stay stable unless an older entry becomes ready; select is then re-evaluated.
- Flush:
  - Clear all valid bits and the age matrix.
  - For each valid entry with uses_rw and rd != 0, clear busy[rd].
  - The dispatch and issue offered in the flush cycle do not transfer.
  - Wakeup in the flush cycle is still applied.
- Simultaneous events:
  - Issue and dispatch in one cycle: occupancy is unchanged. A full queue still shows disp_ready = 0, with no bypass of a freed slot.
  - Wakeup and dispatch set on the same preg: set wins.
  - Wakeup matching an entry issuing this cycle: harmless.
- Reset: all entries invalid, busy table cleared, age cleared, occupancy 0. disp_ready = 0 while rst is high and 1 in the first cycle after. iss_valid = 0.

## Timing
- Dispatch to earliest issue: 1 cycle. Entry written at edge t, iss_valid in cycle t+1 if sources are ready.
- Wakeup to issue: 1 cycle. wb_valid in cycle t, dependent entry issues in t+1.
- Dispatch with a source matching the same-cycle wb_preg is ready at dispatch. The source is not lost.
- One dispatch and one issue per cycle maximum.
- Flush takes effect at the next edge; occupancy = 0 in the following cycle.
- Rst asserted mid-operation clears everything at the next edge, regardless of other inputs.

## Test plan
- Reset, then dispatch 3 independent instructions (tags 1,2,3, all sources ready) with iss_ready = 1. Required: issue in tag order 1,2,3 on consecutive cycles, first one cycle after the first dispatch.
- Dispatch tag 4 writing preg 40, then tag 5 reading rs = 40. Required: tag 5 stalls. Assert wb_valid/wb_preg = 40 at cycle t: tag 5 issues at t+1 and busy[40] is cleared.
- Fill 16 entries with blocked sources. Required: disp_ready = 0 and occupancy = 16. Wake one entry and accept it: disp_ready returns to 1 the next cycle. A new dispatch lands in the freed slot and is youngest by age.
- Hold iss_ready = 0 with 2 ready entries. Required: iss_tag stays on the oldest. Release iss_ready: both issue oldest-first.
- With 5 entries whose destinations are pregs 33..37, assert flush together with disp_valid and wb_valid(preg 20). Required: occupancy 0 next cycle, no dispatch or issue transfer, busy[33..37] and busy[20] cleared.
- Dispatch with rs = 50 busy and wb_preg = 50 in the same cycle. Required: entry is ready and issues the next cycle. Dispatch with rd = 0: busy[0] remains 0.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - dispatch, writeback, issue and flush signals of the issue scheduler
interface issue_scheduler_if #(
   parameter int IQ_DEPTH = 16,
   parameter int PREG_W   = 6,
   parameter int TAG_W    = 5
);
   localparam int OCC_W = $clog2(IQ_DEPTH) + 1;

   logic              disp_valid;
   logic              disp_ready;
   logic              disp_uses_rs;
   logic              disp_uses_rt;
   logic              disp_uses_rw;
   logic [PREG_W-1:0] disp_rs_phys;
   logic [PREG_W-1:0] disp_rt_phys;
   logic [PREG_W-1:0] disp_rd_phys;
   logic [TAG_W-1:0]  disp_tag;
   logic              wb_valid;
   logic [PREG_W-1:0] wb_preg;
   logic              iss_valid;
   logic              iss_ready;
   logic [PREG_W-1:0] iss_rs_phys;
   logic [PREG_W-1:0] iss_rt_phys;
   logic [PREG_W-1:0] iss_rd_phys;
   logic              iss_uses_rw;
   logic [TAG_W-1:0]  iss_tag;
   logic              flush;
   logic [OCC_W-1:0]  occupancy;

   modport master (
      output disp_valid, disp_uses_rs, disp_uses_rt, disp_uses_rw,
             disp_rs_phys, disp_rt_phys, disp_rd_phys, disp_tag,
             wb_valid, wb_preg, iss_ready, flush,
      input  disp_ready, iss_valid, iss_rs_phys, iss_rt_phys, iss_rd_phys,
             iss_uses_rw, iss_tag, occupancy
   );

   modport slave (
      input  disp_valid, disp_uses_rs, disp_uses_rt, disp_uses_rw,
             disp_rs_phys, disp_rt_phys, disp_rd_phys, disp_tag,
             wb_valid, wb_preg, iss_ready, flush,
      output disp_ready, iss_valid, iss_rs_phys, iss_rt_phys, iss_rd_phys,
             iss_uses_rw, iss_tag, occupancy
   );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - out-of-order issue queue with busy table, wakeup and age-matrix oldest-ready select
module issue_scheduler #(
   parameter int IQ_DEPTH  = 16,
   parameter int NUM_PREGS = 64,
   parameter int PREG_W    = 6,
   parameter int TAG_W     = 5
) (
   input logic              clk,
   input logic              rst,
   issue_scheduler_if.slave bus
);
   localparam int IDX_W = $clog2(IQ_DEPTH);
   localparam int OCC_W = IDX_W + 1;

   logic [IQ_DEPTH-1:0]  valid_q, valid_d;
   logic [IQ_DEPTH-1:0]  rs_rdy_q, rs_rdy_d;
   logic [IQ_DEPTH-1:0]  rt_rdy_q, rt_rdy_d;
   logic [IQ_DEPTH-1:0]  uses_rw_q;
   logic [IQ_DEPTH-1:0]  age_q [IQ_DEPTH];
   logic [IQ_DEPTH-1:0]  age_d [IQ_DEPTH];
   logic [PREG_W-1:0]    rs_q  [IQ_DEPTH];
   logic [PREG_W-1:0]    rt_q  [IQ_DEPTH];
   logic [PREG_W-1:0]    rd_q  [IQ_DEPTH];
   logic [TAG_W-1:0]     tag_q [IQ_DEPTH];
   logic [NUM_PREGS-1:0] busy_q, busy_d;
   logic [OCC_W-1:0]     occ_q, occ_d;

   logic [IQ_DEPTH-1:0]  cand, sel_oh;
   logic [IDX_W-1:0]     sel_idx, free_idx;
   logic                 older;
   logic                 disp_fire, iss_fire;
   logic                 new_rs_rdy, new_rt_rdy;

   // An entry is selected when no other candidate is older than it.
   always_comb begin
      cand     = valid_q & rs_rdy_q & rt_rdy_q;
      sel_oh   = '0;
      sel_idx  = '0;
      free_idx = '0;
      older    = 1'b0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
         older = 1'b0;
         for (int k = 0; k < IQ_DEPTH; k++)
            older = older | (cand[k] & age_q[k][i]);
         sel_oh[i] = cand[i] & ~older;
      end
      for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
         if (sel_oh[i])   sel_idx  = IDX_W'(i);
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
   end

   assign bus.disp_ready  = !rst && !bus.flush && (occ_q < OCC_W'(IQ_DEPTH));
   assign bus.iss_valid   = (|cand) && !bus.flush && !rst;
   assign bus.iss_rs_phys = rs_q[sel_idx];
   assign bus.iss_rt_phys = rt_q[sel_idx];
   assign bus.iss_rd_phys = rd_q[sel_idx];
   assign bus.iss_uses_rw = uses_rw_q[sel_idx];
   assign bus.iss_tag     = tag_q[sel_idx];
   assign bus.occupancy   = occ_q;

   assign disp_fire  = bus.disp_valid && bus.disp_ready;
   assign iss_fire   = bus.iss_valid && bus.iss_ready;
   // Same-cycle writeback counts, so a dispatching source is never lost.
   assign new_rs_rdy = !bus.disp_uses_rs || !busy_q[bus.disp_rs_phys] ||
                       (bus.wb_valid && bus.wb_preg == bus.disp_rs_phys);
   assign new_rt_rdy = !bus.disp_uses_rt || !busy_q[bus.disp_rt_phys] ||
                       (bus.wb_valid && bus.wb_preg == bus.disp_rt_phys);

   always_comb begin
      valid_d  = valid_q;
      rs_rdy_d = rs_rdy_q;
      rt_rdy_d = rt_rdy_q;
      busy_d   = busy_q;
      occ_d    = occ_q;
      age_d    = age_q;
      if (bus.wb_valid) begin
         busy_d[bus.wb_preg] = 1'b0;
         for (int i = 0; i < IQ_DEPTH; i++) begin
            if (rs_q[i] == bus.wb_preg) rs_rdy_d[i] = 1'b1;
            if (rt_q[i] == bus.wb_preg) rt_rdy_d[i] = 1'b1;
         end
      end
      if (bus.flush) begin
         for (int i = 0; i < IQ_DEPTH; i++) begin
            if (valid_q[i] && uses_rw_q[i] && rd_q[i] != '0) busy_d[rd_q[i]] = 1'b0;
            age_d[i] = '0;
         end
         valid_d = '0;
         occ_d   = '0;
      end else begin
         if (disp_fire) begin
            for (int i = 0; i < IQ_DEPTH; i++) age_d[i][free_idx] = valid_q[i];
            age_d[free_idx]    = '0;
            valid_d[free_idx]  = 1'b1;
            rs_rdy_d[free_idx] = new_rs_rdy;
            rt_rdy_d[free_idx] = new_rt_rdy;
            if (bus.disp_uses_rw && bus.disp_rd_phys != '0) busy_d[bus.disp_rd_phys] = 1'b1;
         end
         if (iss_fire) begin
            for (int k = 0; k < IQ_DEPTH; k++) age_d[k][sel_idx] = 1'b0;
            age_d[sel_idx]   = '0;
            valid_d[sel_idx] = 1'b0;
         end
         occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         rs_rdy_q <= '0;
         rt_rdy_q <= '0;
         busy_q   <= '0;
         occ_q    <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) age_q[i] <= '0;
      end else begin
         valid_q  <= valid_d;
         rs_rdy_q <= rs_rdy_d;
         rt_rdy_q <= rt_rdy_d;
         busy_q   <= busy_d;
         occ_q    <= occ_d;
         age_q    <= age_d;
      end
   end

   // Payload only matters while the entry is valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (disp_fire) begin
         rs_q[free_idx]      <= bus.disp_rs_phys;
         rt_q[free_idx]      <= bus.disp_rt_phys;
         rd_q[free_idx]      <= bus.disp_rd_phys;
         tag_q[free_idx]     <= bus.disp_tag;
         uses_rw_q[free_idx] <= bus.disp_uses_rw;
      end
   end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard testbench for issue_scheduler
module tb_issue_scheduler;
   localparam int IQ_DEPTH  = 16;
   localparam int NUM_PREGS = 64;
   localparam int PREG_W    = 6;
   localparam int TAG_W     = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   issue_scheduler_if #(.IQ_DEPTH(IQ_DEPTH), .PREG_W(PREG_W), .TAG_W(TAG_W)) bus ();

   issue_scheduler #(.IQ_DEPTH(IQ_DEPTH), .NUM_PREGS(NUM_PREGS), .PREG_W(PREG_W), .TAG_W(TAG_W))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   logic [TAG_W-1:0] exp_q[$];
   logic [TAG_W-1:0] mon_exp;

   // Every issue transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.iss_valid && bus.iss_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: issued tag=%0d, none expected", bus.iss_tag);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.iss_tag !== mon_exp) begin
               n_err++;
               $display("FAIL sb_order: issued tag=%0d want %0d", bus.iss_tag, mon_exp);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.disp_valid   = 1'b0;
      bus.disp_uses_rs = 1'b0;
      bus.disp_uses_rt = 1'b0;
      bus.disp_uses_rw = 1'b0;
      bus.disp_rs_phys = '0;
      bus.disp_rt_phys = '0;
      bus.disp_rd_phys = '0;
      bus.disp_tag     = '0;
      bus.wb_valid     = 1'b0;
      bus.wb_preg      = '0;
      bus.flush        = 1'b0;
   endtask

   task automatic disp(input int tag, input logic urs, input int rs, input logic urt, input int rt,
                       input logic urw, input int rd);
      bus.disp_valid   = 1'b1;
      bus.disp_tag     = TAG_W'(tag);
      bus.disp_uses_rs = urs;
      bus.disp_rs_phys = PREG_W'(rs);
      bus.disp_uses_rt = urt;
      bus.disp_rt_phys = PREG_W'(rt);
      bus.disp_uses_rw = urw;
      bus.disp_rd_phys = PREG_W'(rd);
      bus.wb_valid     = 1'b0;
      bus.flush        = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc(); smp();
      n_cmp++;
      if ({bus.disp_ready, bus.iss_valid} !== 2'b00 || bus.occupancy !== 5'd0) begin
         n_err++;
         $display("FAIL reset_hold: ready=%b valid=%b occ=%0d want 0 0 0", bus.disp_ready, bus.iss_valid, bus.occupancy);
      end
      cyc(); rst = 1'b0; smp();
      n_cmp++;
      if ({bus.disp_ready, bus.iss_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_release: ready=%b valid=%b want 1 0", bus.disp_ready, bus.iss_valid);
      end
   endtask

   task automatic test_in_order();
      cyc(); bus.iss_ready = 1'b1; disp(1, 0, 0, 0, 0, 0, 0); exp_q.push_back(5'd1); smp();
      n_cmp++;
      if ({bus.disp_ready, bus.iss_valid} !== 2'b10) begin
         n_err++; $display("FAIL inorder_c0: ready=%b valid=%b want 1 0", bus.disp_ready, bus.iss_valid);
      end
      cyc(); disp(2, 0, 0, 0, 0, 0, 0); exp_q.push_back(5'd2); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd1}) begin
         n_err++; $display("FAIL inorder_t1: valid=%b tag=%0d want 1 1", bus.iss_valid, bus.iss_tag);
      end
      cyc(); disp(3, 0, 0, 0, 0, 0, 0); exp_q.push_back(5'd3); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd2}) begin
         n_err++; $display("FAIL inorder_t2: valid=%b tag=%0d want 1 2", bus.iss_valid, bus.iss_tag);
      end
      cyc(); idle(); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd3}) begin
         n_err++; $display("FAIL inorder_t3: valid=%b tag=%0d want 1 3", bus.iss_valid, bus.iss_tag);
      end
      cyc(); smp();
      n_cmp++;
      if (bus.iss_valid !== 1'b0 || bus.occupancy !== 5'd0) begin
         n_err++; $display("FAIL inorder_drain: valid=%b occ=%0d want 0 0", bus.iss_valid, bus.occupancy);
      end
   endtask

   task automatic test_wakeup();
      cyc(); disp(4, 0, 0, 0, 0, 1, 40); exp_q.push_back(5'd4); smp();
      cyc(); disp(5, 1, 40, 0, 0, 0, 0); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd4}) begin
         n_err++; $display("FAIL wake_producer: valid=%b tag=%0d want 1 4", bus.iss_valid, bus.iss_tag);
      end
      cyc(); idle(); smp();
      n_cmp++;
      if (bus.iss_valid !== 1'b0 || dut.busy_q[40] !== 1'b1) begin
         n_err++; $display("FAIL wake_stall: valid=%b busy40=%b want 0 1", bus.iss_valid, dut.busy_q[40]);
      end
      cyc(); bus.wb_valid = 1'b1; bus.wb_preg = 6'd40; exp_q.push_back(5'd5); smp();
      n_cmp++;
      if (bus.iss_valid !== 1'b0) begin
         n_err++; $display("FAIL wake_t: valid=%b want 0", bus.iss_valid);
      end
      cyc(); idle(); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag, dut.busy_q[40]} !== {1'b1, 5'd5, 1'b0}) begin
         n_err++; $display("FAIL wake_t1: valid=%b tag=%0d busy40=%b want 1 5 0", bus.iss_valid, bus.iss_tag, dut.busy_q[40]);
      end
      cyc(); smp();
   endtask

   task automatic test_full();
      cyc(); disp(6, 0, 0, 0, 0, 1, 41); exp_q.push_back(5'd6); smp();
      for (int k = 0; k < IQ_DEPTH; k++) begin
         cyc(); disp(8 + k, 1, 41 + k, 0, 0, 1, 42 + k); smp();
      end
      cyc(); disp(31, 0, 0, 0, 0, 0, 0); smp();
      n_cmp++;
      if ({bus.disp_ready, bus.iss_valid} !== 2'b00 || bus.occupancy !== 5'd16) begin
         n_err++; $display("FAIL full_state: ready=%b valid=%b occ=%0d want 0 0 16", bus.disp_ready, bus.iss_valid, bus.occupancy);
      end
      cyc(); bus.wb_valid = 1'b1; bus.wb_preg = 6'd41; exp_q.push_back(5'd8); smp();
      cyc(); bus.wb_valid = 1'b0; smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag, bus.disp_ready} !== {1'b1, 5'd8, 1'b0}) begin
         n_err++; $display("FAIL full_issue: valid=%b tag=%0d ready=%b want 1 8 0", bus.iss_valid, bus.iss_tag, bus.disp_ready);
      end
      cyc(); bus.iss_ready = 1'b0; disp(30, 0, 0, 0, 0, 0, 0); bus.wb_valid = 1'b1; bus.wb_preg = 6'd42; smp();
      n_cmp++;
      if (bus.disp_ready !== 1'b1 || bus.occupancy !== 5'd15) begin
         n_err++; $display("FAIL full_reopen: ready=%b occ=%0d want 1 15", bus.disp_ready, bus.occupancy);
      end
      cyc(); idle(); bus.iss_ready = 1'b1; exp_q.push_back(5'd9); exp_q.push_back(5'd30); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag, dut.valid_q[1], dut.tag_q[1]} !== {1'b1, 5'd9, 1'b1, 5'd30}) begin
         n_err++; $display("FAIL full_slot: valid=%b tag=%0d slot1=%b/%0d want 1 9 1/30", bus.iss_valid, bus.iss_tag, dut.valid_q[1], dut.tag_q[1]);
      end
      cyc(); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd30}) begin
         n_err++; $display("FAIL full_youngest: valid=%b tag=%0d want 1 30", bus.iss_valid, bus.iss_tag);
      end
      cyc(); bus.flush = 1'b1; bus.wb_valid = 1'b1; bus.wb_preg = 6'd43; smp();
      cyc(); idle(); smp();
      n_cmp++;
      if (bus.occupancy !== 5'd0 || dut.busy_q[63:41] !== 23'd0) begin
         n_err++; $display("FAIL full_cleanup: occ=%0d busy=%h want 0 0", bus.occupancy, dut.busy_q[63:41]);
      end
   endtask

   task automatic test_hold();
      cyc(); bus.iss_ready = 1'b0; disp(11, 0, 0, 0, 0, 0, 0); exp_q.push_back(5'd11); smp();
      cyc(); disp(12, 0, 0, 0, 0, 0, 0); exp_q.push_back(5'd12); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd11}) begin
         n_err++; $display("FAIL hold_first: valid=%b tag=%0d want 1 11", bus.iss_valid, bus.iss_tag);
      end
      for (int c = 0; c < 2; c++) begin
         cyc(); idle(); smp();
         n_cmp++;
         if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd11}) begin
            n_err++; $display("FAIL hold_stable: cycle=%0d valid=%b tag=%0d want 1 11", c, bus.iss_valid, bus.iss_tag);
         end
      end
      cyc(); bus.iss_ready = 1'b1; smp();
      cyc(); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd12}) begin
         n_err++; $display("FAIL hold_second: valid=%b tag=%0d want 1 12", bus.iss_valid, bus.iss_tag);
      end
      cyc(); smp();
   endtask

   task automatic test_flush();
      cyc(); bus.iss_ready = 1'b1; disp(7, 0, 0, 0, 0, 1, 20); exp_q.push_back(5'd7); smp();
      cyc(); idle(); smp();
      for (int k = 0; k < 5; k++) begin
         cyc(); bus.iss_ready = 1'b0; disp(1 + k, 0, 0, 0, 0, 1, 33 + k); smp();
      end
      cyc(); disp(6, 0, 0, 0, 0, 1, 38); bus.flush = 1'b1; bus.wb_valid = 1'b1; bus.wb_preg = 6'd20;
      bus.iss_ready = 1'b1; smp();
      n_cmp++;
      if ({bus.disp_ready, bus.iss_valid, dut.busy_q[37:33], dut.busy_q[20]} !== {2'b00, 5'b11111, 1'b1}
          || bus.occupancy !== 5'd5) begin
         n_err++; $display("FAIL flush_cycle: ready=%b valid=%b busy=%b/%b occ=%0d want 0 0 11111/1 5",
                           bus.disp_ready, bus.iss_valid, dut.busy_q[37:33], dut.busy_q[20], bus.occupancy);
      end
      cyc(); idle(); smp();
      n_cmp++;
      if (bus.occupancy !== 5'd0 || bus.iss_valid !== 1'b0 || {dut.busy_q[38:33], dut.busy_q[20]} !== 7'd0) begin
         n_err++; $display("FAIL flush_after: occ=%0d valid=%b busy=%b/%b want 0 0 0/0",
                           bus.occupancy, bus.iss_valid, dut.busy_q[38:33], dut.busy_q[20]);
      end
   endtask

   task automatic test_same_cycle_wake();
      cyc(); bus.iss_ready = 1'b1; disp(8, 0, 0, 0, 0, 1, 50); exp_q.push_back(5'd8); smp();
      cyc(); idle(); smp();
      cyc(); disp(9, 1, 50, 0, 0, 0, 0); bus.wb_valid = 1'b1; bus.wb_preg = 6'd50; exp_q.push_back(5'd9); smp();
      n_cmp++;
      if (dut.busy_q[50] !== 1'b1) begin
         n_err++; $display("FAIL samewake_pre: busy50=%b want 1", dut.busy_q[50]);
      end
      cyc(); disp(10, 0, 0, 0, 0, 1, 0); exp_q.push_back(5'd10); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 5'd9}) begin
         n_err++; $display("FAIL samewake_issue: valid=%b tag=%0d want 1 9", bus.iss_valid, bus.iss_tag);
      end
      cyc(); idle(); smp();
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag, dut.busy_q[0]} !== {1'b1, 5'd10, 1'b0}) begin
         n_err++; $display("FAIL rd_zero: valid=%b tag=%0d busy0=%b want 1 10 0", bus.iss_valid, bus.iss_tag, dut.busy_q[0]);
      end
      cyc(); smp();
   endtask

   task automatic test_reset_mid();
      cyc(); bus.iss_ready = 1'b0; disp(13, 0, 0, 0, 0, 1, 60); smp();
      cyc(); disp(14, 0, 0, 0, 0, 0, 0); rst = 1'b1; smp();
      n_cmp++;
      if ({bus.disp_ready, bus.iss_valid} !== 2'b00) begin
         n_err++; $display("FAIL rstmid_hold: ready=%b valid=%b want 0 0", bus.disp_ready, bus.iss_valid);
      end
      cyc(); rst = 1'b0; idle(); smp();
      n_cmp++;
      if ({bus.disp_ready, bus.iss_valid, dut.busy_q[60]} !== 3'b100 || bus.occupancy !== 5'd0) begin
         n_err++; $display("FAIL rstmid_clear: ready=%b valid=%b busy60=%b occ=%0d want 1 0 0 0",
                           bus.disp_ready, bus.iss_valid, dut.busy_q[60], bus.occupancy);
      end
   endtask

   initial begin
      idle();
      bus.iss_ready = 1'b0;
      test_reset();
      test_in_order();
      test_wakeup();
      test_full();
      test_hold();
      test_flush();
      test_same_cycle_wake();
      test_reset_mid();
      cyc(); smp();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL sb_leftover: %0d expected issues never seen, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
